// File: rtl/regfile_rename_pkg.sv
// Shared definitions for the rename-aware architectural register file.
package regfile_rename_pkg;

  localparam int unsigned REG_WIDTH  = 5;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ROB_WIDTH  = 4;

  typedef logic [REG_WIDTH-1:0]  reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ROB_WIDTH-1:0]  rob_tag_t;

  localparam reg_addr_t ZERO_REG   = '0;
  localparam rob_tag_t  NO_REORDER = '0;
  localparam logic      TRUE       = 1'b1;
  localparam logic      FALSE      = 1'b0;

  // One architectural register: committed value plus pending-producer tag.
  typedef struct packed {
    data_t    value;
    logic     busy;
    rob_tag_t reorder;
  } reg_entry_t;

  localparam reg_entry_t EMPTY_ENTRY = '{value: '0, busy: FALSE, reorder: NO_REORDER};

endpackage

// File: rtl/regfile_rename_if.sv
// Decoder query/rename and ROB commit/flush signals of the register file.
interface regfile_rename_if;
  import regfile_rename_pkg::*;

  logic      in_rdy;
  logic      in_flush_enable;
  reg_addr_t in_decoder_rs;
  reg_addr_t in_decoder_rt;
  logic      out_decoder_rs_busy;
  rob_tag_t  out_decoder_rs_reorder;
  data_t     out_decoder_rs_value;
  logic      out_decoder_rt_busy;
  rob_tag_t  out_decoder_rt_reorder;
  data_t     out_decoder_rt_value;
  logic      in_decoder_rename_enable;
  reg_addr_t in_decoder_rd;
  rob_tag_t  in_decoder_reorder;
  logic      in_rob_commit_enable;
  reg_addr_t in_rob_commit_rd;
  data_t     in_rob_commit_value;
  rob_tag_t  in_rob_commit_reorder;

  // Decoder/ROB side
  modport master (
    output in_rdy, in_flush_enable, in_decoder_rs, in_decoder_rt,
           in_decoder_rename_enable, in_decoder_rd, in_decoder_reorder,
           in_rob_commit_enable, in_rob_commit_rd, in_rob_commit_value, in_rob_commit_reorder,
    input  out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value,
           out_decoder_rt_busy, out_decoder_rt_reorder, out_decoder_rt_value
  );

  // Register file side
  modport slave (
    input  in_rdy, in_flush_enable, in_decoder_rs, in_decoder_rt,
           in_decoder_rename_enable, in_decoder_rd, in_decoder_reorder,
           in_rob_commit_enable, in_rob_commit_rd, in_rob_commit_value, in_rob_commit_reorder,
    output out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value,
           out_decoder_rt_busy, out_decoder_rt_reorder, out_decoder_rt_value
  );

endinterface

// File: rtl/regfile_read_port.sv
// Combinational register lookup; x0 always reads as idle zero.
// Optional REGFILE_COMMIT_BYPASS_EN forwards a same-cycle matching commit.
module regfile_read_port
  import regfile_rename_pkg::*;
#(
  parameter int unsigned REG_NUM = 32
) (
  input  reg_entry_t regs_i [REG_NUM],
  input  reg_addr_t  addr_i,
`ifdef REGFILE_COMMIT_BYPASS_EN
  input  logic       commit_en_i,
  input  reg_addr_t  commit_rd_i,
  input  data_t      commit_value_i,
  input  rob_tag_t   commit_reorder_i,
`endif
  output logic       busy_o,
  output rob_tag_t   reorder_o,
  output data_t      value_o
);

  // Select the addressed entry, masking x0 and applying the commit bypass
  always_comb begin
    busy_o    = regs_i[addr_i].busy;
    reorder_o = regs_i[addr_i].reorder;
    value_o   = regs_i[addr_i].value;
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (commit_en_i && (commit_rd_i == addr_i) && (commit_reorder_i == regs_i[addr_i].reorder)) begin
      busy_o    = FALSE;
      reorder_o = NO_REORDER;
      value_o   = commit_value_i;
    end
`endif
    if (addr_i == ZERO_REG) begin
      busy_o    = FALSE;
      reorder_o = NO_REORDER;
      value_o   = '0;
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register ROB rename tags.
// Optional feature macro: REGFILE_COMMIT_BYPASS_EN (same-cycle commit forwarding).
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int unsigned REG_NUM = 32
) (
  input logic            in_clk,
  input logic            in_rst_n,
  regfile_rename_if.slave bus
);

  reg_entry_t regs_q [REG_NUM];
  reg_entry_t regs_d [REG_NUM];

  // Next state: commit writes value and retires a matching tag; flush clears
  // every tag; otherwise a rename (applied after commit, so it wins) marks busy.
  always_comb begin
    regs_d = regs_q;
    if (bus.in_rob_commit_enable && (bus.in_rob_commit_rd != ZERO_REG)) begin
      regs_d[bus.in_rob_commit_rd].value = bus.in_rob_commit_value;
      if (regs_q[bus.in_rob_commit_rd].busy &&
          (regs_q[bus.in_rob_commit_rd].reorder == bus.in_rob_commit_reorder)) begin
        regs_d[bus.in_rob_commit_rd].busy    = FALSE;
        regs_d[bus.in_rob_commit_rd].reorder = NO_REORDER;
      end
    end
    if (bus.in_flush_enable) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs_d[i].busy    = FALSE;
        regs_d[i].reorder = NO_REORDER;
      end
    end else if (bus.in_decoder_rename_enable && (bus.in_decoder_rd != ZERO_REG)) begin
      regs_d[bus.in_decoder_rd].busy    = TRUE;
      regs_d[bus.in_decoder_rd].reorder = bus.in_decoder_reorder;
    end
  end

  // State register: async clear, updates only while globally enabled
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= EMPTY_ENTRY;
      end
    end else if (bus.in_rdy) begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(.REG_NUM(REG_NUM)) u_rs_port (
    .regs_i           (regs_q),
    .addr_i           (bus.in_decoder_rs),
`ifdef REGFILE_COMMIT_BYPASS_EN
    .commit_en_i      (bus.in_rob_commit_enable),
    .commit_rd_i      (bus.in_rob_commit_rd),
    .commit_value_i   (bus.in_rob_commit_value),
    .commit_reorder_i (bus.in_rob_commit_reorder),
`endif
    .busy_o           (bus.out_decoder_rs_busy),
    .reorder_o        (bus.out_decoder_rs_reorder),
    .value_o          (bus.out_decoder_rs_value)
  );

  regfile_read_port #(.REG_NUM(REG_NUM)) u_rt_port (
    .regs_i           (regs_q),
    .addr_i           (bus.in_decoder_rt),
`ifdef REGFILE_COMMIT_BYPASS_EN
    .commit_en_i      (bus.in_rob_commit_enable),
    .commit_rd_i      (bus.in_rob_commit_rd),
    .commit_value_i   (bus.in_rob_commit_value),
    .commit_reorder_i (bus.in_rob_commit_reorder),
`endif
    .busy_o           (bus.out_decoder_rt_busy),
    .reorder_o        (bus.out_decoder_rt_reorder),
    .value_o          (bus.out_decoder_rt_value)
  );

endmodule

// File: tb/tb_regfile_rename.sv
// Self-checking bench: directed literal cases plus randomized traffic
// compared every cycle against a behavioural register-file model.
module tb_regfile_rename;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_rename_if bus ();

  regfile_rename #(.REG_NUM(32)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus)
  );

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Model update: apply the architectural rules on each enabled clock edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (bus.in_rdy) begin
      if (bus.in_rob_commit_enable && bus.in_rob_commit_rd != 0) begin
        m_val[bus.in_rob_commit_rd] = bus.in_rob_commit_value;
        if (m_busy[bus.in_rob_commit_rd] && m_tag[bus.in_rob_commit_rd] == bus.in_rob_commit_reorder) begin
          m_busy[bus.in_rob_commit_rd] = 1'b0;
          m_tag[bus.in_rob_commit_rd]  = '0;
        end
      end
      if (bus.in_flush_enable) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 1'b0; m_tag[i] = '0;
        end
      end else if (bus.in_decoder_rename_enable && bus.in_decoder_rd != 0) begin
        m_busy[bus.in_decoder_rd] = 1'b1;
        m_tag[bus.in_decoder_rd]  = bus.in_decoder_reorder;
      end
    end
  end

  function automatic logic [63:0] model_read(input logic [4:0] a);
    logic [63:0] r;
    if (a == 0) return 64'd0;
    r = {27'd0, m_busy[a], m_tag[a], m_val[a]};
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (bus.in_rob_commit_enable && bus.in_rob_commit_rd == a && bus.in_rob_commit_reorder == m_tag[a])
      r = {27'd0, 1'b0, 4'd0, bus.in_rob_commit_value};
`endif
    return r;
  endfunction

  // Compare process: both read ports against the model on every falling edge
  always @(negedge clk) begin
    chk("rs_port", {27'd0, bus.out_decoder_rs_busy, bus.out_decoder_rs_reorder, bus.out_decoder_rs_value},
        model_read(bus.in_decoder_rs));
    chk("rt_port", {27'd0, bus.out_decoder_rt_busy, bus.out_decoder_rt_reorder, bus.out_decoder_rt_value},
        model_read(bus.in_decoder_rt));
  end

  task automatic idle();
    bus.in_rdy = 1'b1;
    bus.in_flush_enable = 1'b0;
    bus.in_decoder_rename_enable = 1'b0;
    bus.in_decoder_rd = '0;
    bus.in_decoder_reorder = '0;
    bus.in_rob_commit_enable = 1'b0;
    bus.in_rob_commit_rd = '0;
    bus.in_rob_commit_value = '0;
    bus.in_rob_commit_reorder = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic ren(input logic [4:0] rd, input logic [3:0] tag);
    bus.in_decoder_rename_enable = 1'b1;
    bus.in_decoder_rd = rd;
    bus.in_decoder_reorder = tag;
  endtask

  task automatic cmt(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] v);
    bus.in_rob_commit_enable = 1'b1;
    bus.in_rob_commit_rd = rd;
    bus.in_rob_commit_reorder = tag;
    bus.in_rob_commit_value = v;
  endtask

  // Literal expectation on both read ports for one address
  task automatic rd_chk(input string name, input logic [4:0] a, input logic b,
                        input logic [3:0] t, input logic [31:0] v);
    bus.in_decoder_rs = a;
    bus.in_decoder_rt = a;
    #1;
    chk({name, "_rs"}, {27'd0, bus.out_decoder_rs_busy, bus.out_decoder_rs_reorder, bus.out_decoder_rs_value},
        {27'd0, b, t, v});
    chk({name, "_rt"}, {27'd0, bus.out_decoder_rt_busy, bus.out_decoder_rt_reorder, bus.out_decoder_rt_value},
        {27'd0, b, t, v});
  endtask

  initial begin
    logic [4:0] a;
    idle();
    bus.in_decoder_rs = '0;
    bus.in_decoder_rt = '0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    rd_chk("reset_x5", 5'd5, 1'b0, 4'd0, 32'd0);

    // Rename then commit with matching tag
    ren(5'd5, 4'd3); step(); idle();
    rd_chk("ren_x5", 5'd5, 1'b1, 4'd3, 32'd0);
    cmt(5'd5, 4'd3, 32'hDEADBEEF);
`ifdef REGFILE_COMMIT_BYPASS_EN
    rd_chk("commit_cycle_x5", 5'd5, 1'b0, 4'd0, 32'hDEADBEEF);
`else
    rd_chk("commit_cycle_x5", 5'd5, 1'b1, 4'd3, 32'd0);
`endif
    step(); idle();
    rd_chk("commit_x5", 5'd5, 1'b0, 4'd0, 32'hDEADBEEF);

    // Older commit must not clear a younger rename
    ren(5'd7, 4'd2); step(); idle();
    ren(5'd7, 4'd4); step(); idle();
    cmt(5'd7, 4'd2, 32'h11); step(); idle();
    rd_chk("stale_commit_x7", 5'd7, 1'b1, 4'd4, 32'h11);

    // Same-cycle commit and rename of one register
    cmt(5'd9, 4'd6, 32'h22); ren(5'd9, 4'd8); step(); idle();
    rd_chk("commit_rename_x9", 5'd9, 1'b1, 4'd8, 32'h22);

    // Flush with concurrent rename (dropped) and commit (value kept)
    ren(5'd1, 4'd1); step(); idle();
    ren(5'd2, 4'd2); step(); idle();
    ren(5'd3, 4'd3); step(); idle();
    bus.in_flush_enable = 1'b1; ren(5'd4, 4'd5); cmt(5'd2, 4'd2, 32'h33); step(); idle();
    rd_chk("flush_x1", 5'd1, 1'b0, 4'd0, 32'd0);
    rd_chk("flush_x2", 5'd2, 1'b0, 4'd0, 32'h33);
    rd_chk("flush_x3", 5'd3, 1'b0, 4'd0, 32'd0);
    rd_chk("flush_x4", 5'd4, 1'b0, 4'd0, 32'd0);
    rd_chk("flush_x7", 5'd7, 1'b0, 4'd0, 32'h11);

    // x0 ignores writes and renames
    ren(5'd0, 4'd7); cmt(5'd0, 4'd7, 32'h44); step(); idle();
    rd_chk("x0", 5'd0, 1'b0, 4'd0, 32'd0);

    // Global enable low freezes state
    bus.in_rdy = 1'b0; ren(5'd6, 4'd9); cmt(5'd6, 4'd9, 32'h55); step(); idle();
    rd_chk("rdy_low_x6", 5'd6, 1'b0, 4'd0, 32'd0);

    // Randomized traffic; the compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      idle();
      bus.in_rdy = ($urandom_range(0, 9) != 0);
      bus.in_flush_enable = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) ren(5'($urandom_range(0, 31)), 4'($urandom_range(1, 15)));
      if ($urandom_range(0, 1) == 1) begin
        a = 5'($urandom_range(0, 31));
        cmt(a, ($urandom_range(0, 2) != 0) ? m_tag[a] : 4'($urandom_range(0, 15)), $urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.in_decoder_rs = bus.in_rob_commit_rd;
        bus.in_decoder_rt = bus.in_decoder_rd;
      end else begin
        bus.in_decoder_rs = 5'($urandom_range(0, 31));
        bus.in_decoder_rt = 5'($urandom_range(0, 31));
      end
      step();
    end

    // Asynchronous reset mid-run: outputs clear without a clock edge
    idle();
    ren(5'd12, 4'd7); cmt(5'd13, 4'd0, 32'hA5A5A5A5); step(); idle();
    rd_chk("pre_reset_x12", 5'd12, 1'b1, 4'd7, m_val[12]);
    #1;
    rst_n = 1'b0;
    rd_chk("async_reset_x12", 5'd12, 1'b0, 4'd0, 32'd0);
    rd_chk("async_reset_x13", 5'd13, 1'b0, 4'd0, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    rd_chk("post_reset_x13", 5'd13, 1'b0, 4'd0, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags. Sits directly downstream of the reorder buffer's commit port and alongside the decoder.
- At issue, the decoder queries rs/rt and receives either a committed value or the ROB tag of the pending producer.
- The decoder also renames rd to the newly allocated ROB tail.
- ROB commits write values back and clear matching tags. ROB flush discards all pending tags.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired to zero).
- NO_REORDER, 0, tag value meaning "no pending producer"; valid ROB tags are 1..15.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst_n  input  1  reset, asynchronous, active-low.
- in_rdy  input  1  global enable; when low, all state holds.
- in_flush_enable  input  1  ROB mispredict flush.
- in_decoder_rs  input  5  source register 1 address.
- in_decoder_rt  input  5  source register 2 address.
- out_decoder_rs_busy  output  1  rs has a pending producer.
- out_decoder_rs_reorder  output  4  ROB tag of the rs producer; NO_REORDER when not busy.
- out_decoder_rs_value  output  32  committed rs value.
- out_decoder_rt_busy  output  1  as rs, for rt.
- out_decoder_rt_reorder  output  4  as rs, for rt.
- out_decoder_rt_value  output  32  as rs, for rt.
- in_decoder_rename_enable  input  1  rename rd this cycle.
- in_decoder_rd  input  5  destination register.
- in_decoder_reorder  input  4  ROB tail tag allocated to rd.
- in_rob_commit_enable  input  1  commit writeback valid.
- in_rob_commit_rd  input  5  commit destination.
- in_rob_commit_value  input  32  commit data.
- in_rob_commit_reorder  input  4  tag of the committing entry.

Behaviour:
- State per register: value[31:0], busy, reorder[3:0].
- Reset (async, in_rst_n low): all value=0, busy=0, reorder=NO_REORDER. Outputs follow combinationally: busy=0, reorder=0, value=0.
- Reads are combinational, zero latency.
- Address 0 always reads busy=0, reorder=0, value=0, regardless of writes or renames.
- All state updates occur on the rising edge when in_rdy=1.
- Commit, when enabled and rd!=0:
  - value[rd] <= commit_value unconditionally.
  - If busy[rd] and reorder[rd]==commit_reorder, then busy <= 0 and reorder <= 0.
  - A mismatched tag (a younger rename is pending) leaves busy and reorder untouched.
- Rename, when enabled, rd!=0 and no flush: busy[rd] <= 1, reorder[rd] <= in_decoder_reorder.
- Same cycle, same rd, commit and rename: the value is written and the rename wins, giving busy=1 with the new tag.
- Flush: every busy <= 0 and every reorder <= 0.
  - A commit in the flush cycle still writes its value.
  - A rename in the flush cycle is dropped.
- Commit and rename to rd=0 are ignored.
- in_rdy=0: no updates; outputs still reflect current state.

Optional Feature:
- REGFILE_COMMIT_BYPASS_EN defined:
  - A read whose address equals commit_rd (nonzero), while commit is enabled and the tag equals that register's current reorder, returns busy=0, reorder=0, value=commit_value in the same cycle.
- Not defined:
  - Reads reflect registered state only; the decoder sees busy with the committing tag for that one cycle and resolves it through the ROB ready/value query.
  - Adds no logic on the read path.

Decomposition:
- Shared def package holds REG_WIDTH(4:0), DATA_WIDTH(31:0), ROB_WIDTH(3:0), ZERO_REG, NO_REORDER, TRUE/FALSE.
- One sub-module, regfile_read_port: combinational lookup plus optional bypass, instantiated twice (rs, rt).

Test Plan:
- Reset, then read x5 -> busy=0, reorder=0, value=0. Set in_rst_n low mid-run -> all outputs 0 immediately, without waiting for a clock edge.
- Rename x5 with tag 3; next cycle read x5 -> busy=1, reorder=3. Commit x5 with tag 3, value 0xDEADBEEF -> next cycle busy=0, value=0xDEADBEEF. With bypass, busy=0 and value=0xDEADBEEF in the commit cycle itself.
- Rename x7 with tag 2, then x7 with tag 4; commit x7 with tag 2, value 0x11 -> value=0x11, busy=1, reorder=4.
- Same cycle: commit x9 with tag 6, value 0x22, and rename x9 with tag 8 -> value=0x22, busy=1, reorder=8.
- Rename x1..x3 with tags 1..3, then flush together with rename x4 tag 5 and commit x2 tag 2, value 0x33 -> all busy=0, x4 not busy, x2=0x33.
- Rename and commit x0 with value 0x44 -> x0 reads busy=0, value=0. With in_rdy=0, rename x6 -> no change.
